dct_coef_mac: RTL
=================

// Module: dct_coef_mac
// PURPOSE
//  Streaming 2-D DCT coefficient engine. It computes one coefficient F(k1,k2) of an NxN pixel block.
//  k1 and k2 are selected at run time. Pixels stream in raster order, and the engine multiply-accumulates
//  each pixel against an internally generated separable cosine product.
//  Replaces the fixed per-(k1,k2) combinational cosine tables in the dct path with one parametrised sequential unit.
// PARAMETERS
//  N        8   block edge; power of two, >=2; L = $clog2(N)
//  PIX_W    8   unsigned pixel width
//  COS_FRAC 8   fractional bits of cosine terms
//  ACC_W    32  signed accumulator / coefficient width
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  start      in   1            begin a block; sampled only in IDLE
//  k1         in   L            row frequency; latched on accepted start
//  k2         in   L            column frequency; latched on accepted start
//  pix_valid  in   1            pixel data valid
//  pix_ready  out  1            engine accepts a pixel
//  pix_data   in   PIX_W        unsigned pixel sample
//  coef_valid out  1            coefficient available
//  coef_ready in   1            downstream accepts the coefficient
//  coef_data  out  ACC_W        signed coefficient, COS_FRAC fractional bits
//  busy       out  1            high in ACCUM and DONE
// BEHAVIOUR
//  Reset:
//  - All outputs are 0, the FSM is IDLE, and acc and idx are cleared.
//  - Reset asserted mid-operation aborts the block with no output.
//  1-D table:
//  - c[k][n] = round(2^COS_FRAC * cos((2n+1)*k*pi/(2N))), signed COS_FRAC+2 bits.
//  - Built at elaboration as localparams.
//  Product:
//  - cp = (c[k1][n1] * c[k2][n2] + 2^(COS_FRAC-1)) >>> COS_FRAC, arithmetic shift.
//  Pixel mapping:
//  - idx is a 2L-bit counter; n1 = idx[2L-1:L] (row), n2 = idx[L-1:0] (column).
//  FSM IDLE:
//  - pix_ready=0.
//  - start=1: latch k1/k2, acc<=0, idx<=0, go to ACCUM.
//  FSM ACCUM:
//  - pix_ready=1.
//  - On pix_valid&pix_ready: acc <= acc + p*cp, idx <= idx+1.
//  - When the transfer with idx=N*N-1 occurs, go to DONE.
//  - idx wraps to 0 at that point.
//  FSM DONE:
//  - coef_valid=1, pix_ready=0, and coef_data=acc, held stable until coef_ready.
//  - On coef_valid&coef_ready, go to IDLE.
//  Handshake and latency:
//  - coef_valid rises on the cycle after the last pixel transfer.
//  - A single-cycle MAC gives N*N pixel cycles plus 1 when pix_valid is held high.
//  - start is ignored outside IDLE, including on the DONE handshake cycle.
//  - A new block needs start in IDLE, so the minimum gap between coefficients is 1 cycle of IDLE.
//  - pix_valid in IDLE or DONE is ignored; no pixel is consumed.
//  - k1/k2 changes after the start cycle have no effect.
//  Arithmetic:
//  - p is a signed PIX_W+1 operand.
//  - acc is two's complement, ACC_W bits; overflow wraps with no saturation.
// CONFIGURATION
//  DCT_LEVEL_SHIFT_EN:
//  - Defined: p = pix_data - 2^(PIX_W-1), so for PIX_W=8, 128 maps to 0.
//  - Undefined: p = zero-extended pix_data.
//  - All other behaviour is identical either way.
// TESTING
//  All scenarios use N=8, PIX_W=8, COS_FRAC=8.
//  1. DC: macro off, k=(0,0), 64 pixels of 100, pix_valid held high.
//     -> coef_data=0x190000, coef_valid 65 cycles after the first transfer.
//  2. AC constant: macro off, k=(4,3), 64 pixels of 200 -> coef_data=0.
//  3. Impulse: macro off, k=(4,3), pixel idx0=1 and the other 63 pixels 0.
//     -> cp=(181*213+128)>>>8, so coef_data=151.
//  4. Level shift: macro on, k=(0,0), 64 pixels of 128 -> coef_data=0.
//     Same block with pixels of 129 -> coef_data=64*256=16384.
//  5. Backpressure:
//     - pix_valid toggling 1/0 gives a result identical to scenario 1, and pix_ready stays 1 throughout ACCUM.
//     - coef_ready low for 5 cycles: coef_valid and coef_data stay stable, and pix_ready stays 0.
//     - A start pulse in DONE is ignored.
//  6. Reset: rst pulse after 30 pixels.
//     -> all outputs 0 on the same cycle (asynchronous), FSM IDLE.
//     -> A fresh start with scenario 1 data returns 0x190000.

Source files
------------

// File: rtl/dct_coef_mac_if.sv
// Handshake bundle for dct_coef_mac: block start / frequency select, pixel stream in, coefficient out.
interface dct_coef_mac_if #(
   parameter int L     = 3,
   parameter int PIX_W = 8,
   parameter int ACC_W = 32
);
   logic             start;
   logic [L-1:0]     k1;
   logic [L-1:0]     k2;
   logic             pix_valid;
   logic             pix_ready;
   logic [PIX_W-1:0] pix_data;
   logic             coef_valid;
   logic             coef_ready;
   logic [ACC_W-1:0] coef_data;
   logic             busy;

   modport master (
      output start, k1, k2, pix_valid, pix_data, coef_ready,
      input  pix_ready, coef_valid, coef_data, busy
   );

   modport slave (
      input  start, k1, k2, pix_valid, pix_data, coef_ready,
      output pix_ready, coef_valid, coef_data, busy
   );
endinterface

// File: rtl/dct_coef_mac.sv
// Streaming 2-D DCT coefficient engine: MACs an NxN raster block against a separable cosine product.
// Optional macro DCT_LEVEL_SHIFT_EN recentres pixels by -2^(PIX_W-1) before the multiply.
module dct_coef_mac #(
   parameter int N        = 8,
   parameter int PIX_W    = 8,
   parameter int COS_FRAC = 8,
   parameter int ACC_W    = 32
) (
   input  logic         clk,
   input  logic         rst,
   dct_coef_mac_if.slave bus
);
   localparam int L  = $clog2(N);
   localparam int CW = COS_FRAC + 2;
   localparam int PW = PIX_W + 1;
   localparam int MW = 2 * CW;
   localparam int TW = PW + MW;

   // Round half away from zero so the table is symmetric in sign.
   function automatic logic [N*N*CW-1:0] build_cos_tab();
      logic [N*N*CW-1:0] tab;
      real pi;
      real r;
      int  v;
      pi  = 3.14159265358979323846;
      tab = '0;
      for (int k = 0; k < N; k++) begin
         for (int n = 0; n < N; n++) begin
            r = $cos(real'((2*n+1)*k) * pi / real'(2*N)) * real'(2**COS_FRAC);
            v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
            tab[(k*N+n)*CW +: CW] = CW'(v);
         end
      end
      return tab;
   endfunction

   localparam logic [N*N*CW-1:0]    COS_TAB = build_cos_tab();
   localparam logic signed [MW-1:0] RND     = MW'(1) <<< (COS_FRAC-1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_DONE = 2'd2} state_t;

   state_t                state_q, state_d;
   logic [L-1:0]          k1_q, k1_d;
   logic [L-1:0]          k2_q, k2_d;
   logic [2*L-1:0]        idx_q, idx_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;

   logic signed [CW-1:0]  cos_lut [N*N];
   logic [L-1:0]          n1, n2;
   logic signed [CW-1:0]  c1, c2;
   logic signed [MW-1:0]  prod, cp;
   logic signed [PW-1:0]  p;
   logic signed [TW-1:0]  term;
   logic                  xfer, last;

   // Index {k,n} equals k*N+n because N is a power of two.
   for (genvar g = 0; g < N*N; g++) begin : g_lut
      assign cos_lut[g] = COS_TAB[g*CW +: CW];
   end

   assign n1 = idx_q[2*L-1:L];
   assign n2 = idx_q[L-1:0];
   assign c1 = cos_lut[{k1_q, n1}];
   assign c2 = cos_lut[{k2_q, n2}];

   assign prod = MW'(c1) * MW'(c2);
   assign cp   = (prod + RND) >>> COS_FRAC;

`ifdef DCT_LEVEL_SHIFT_EN
   localparam logic [PW-1:0] HALF = PW'(1) << (PIX_W-1);
   assign p = $signed({1'b0, bus.pix_data} - HALF);
`else
   assign p = $signed({1'b0, bus.pix_data});
`endif

   assign term = TW'(p) * TW'(cp);
   assign xfer = (state_q == S_ACCUM) && bus.pix_valid;
   assign last = (idx_q == {(2*L){1'b1}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start)     state_d = S_ACCUM;
         S_ACCUM: if (xfer && last)  state_d = S_DONE;
         S_DONE:  if (bus.coef_ready) state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.pix_ready  = 1'b0;
      bus.coef_valid = 1'b0;
      bus.busy       = 1'b0;
      bus.coef_data  = '0;
      case (state_q)
         S_ACCUM: begin
            bus.pix_ready = 1'b1;
            bus.busy      = 1'b1;
         end
         S_DONE: begin
            bus.coef_valid = 1'b1;
            bus.busy       = 1'b1;
            bus.coef_data  = acc_q;
         end
         default: ;
      endcase
   end

   // idx rolls over to 0 on the last transfer, ready for the next block.
   always_comb begin
      k1_d  = k1_q;
      k2_d  = k2_q;
      idx_d = idx_q;
      acc_d = acc_q;
      if (state_q == S_IDLE && bus.start) begin
         k1_d  = bus.k1;
         k2_d  = bus.k2;
         idx_d = '0;
         acc_d = '0;
      end else if (xfer) begin
         acc_d = acc_q + ACC_W'(term);
         idx_d = idx_q + (2*L)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k1_q  <= '0;
         k2_q  <= '0;
         idx_q <= '0;
         acc_q <= '0;
      end else begin
         k1_q  <= k1_d;
         k2_q  <= k2_d;
         idx_q <= idx_d;
         acc_q <= acc_d;
      end
   end
endmodule
